// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
//
// Memory-side responder for the SLC-3 CPU memory bus. It accepts level-held
// read/write requests, inserts WAIT_STATES idle cycles, then serves the access
// from an on-chip word RAM or from the memory-mapped I/O word at IO_ADDR
// (switches on read, hex display register on write). Completion is signalled
// with a one-cycle mem_ready pulse.
//
// Handshake: mem_rd / mem_wr act as a level "valid". The requester holds the
// request and its address/data stable until it observes mem_ready=1. mem_ready
// is the "ready" strobe and is high for exactly one cycle per transaction. The
// responder does not accept a new request until both mem_rd and mem_wr have
// been seen low, so back-to-back requests need one idle cycle between them.
//
// Optional build macro RAM_CLEAR_EN: when defined, the RAM is zero-filled
// (one word per cycle) after every reset release before any request is taken.
//
// Ports:
//   Clk            in   system clock, rising edge
//   Reset          in   asynchronous active-high reset
//   mem_rd         in   read request (level)
//   mem_wr         in   write request (level, wins over mem_rd)
//   ADDR           in   request address
//   Data_from_CPU  in   write data
//   Data_to_CPU    out  read data, held until the next read completes
//   mem_ready      out  one-cycle completion pulse
//   busy           out  high whenever the FSM is not IDLE
//   SW             in   board switches (asynchronous, synchronized here)
//   hex_data       out  hex display register
//   state_dbg      out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module mem_io_responder #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                DEPTH_LOG2  = 8,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              mem_ready,
    output logic              busy,
    input  logic [9:0]        SW,
    output logic [DATA_W-1:0] hex_data,
    output logic [2:0]        state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Counter must hold WAIT_STATES; keep at least one bit when it is 0 or 1.
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

`ifdef RAM_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_data;
    logic                cap_wr;
    logic [9:0]          sw_meta;
    logic [9:0]          sw_sync;

    logic                capture;
    logic                io_hit;
    logic                ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   io_word;

    logic [DATA_W-1:0]   ram [0:DEPTH-1];

`ifdef RAM_CLEAR_EN
    logic [DEPTH_LOG2-1:0] clr_addr;
`endif

    assign io_hit    = (cap_addr == IO_ADDR);
    assign io_word   = {{(DATA_W-10){1'b0}}, sw_sync};
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = cap_addr[DEPTH_LOG2-1:0];
        ram_wdata  = cap_data;

        case (state)
            S_IDLE: begin
                if (mem_rd || mem_wr) begin
                    capture    = 1'b1;
                    state_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter was loaded with WAIT_STATES; leaving when it
                // reads 1 gives exactly WAIT_STATES cycles in this state.
                if (wait_cnt <= CNT_W'(1)) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_we     = cap_wr && !io_hit;
                state_next = S_DONE;
            end
            S_DONE: begin
                if (!mem_rd && !mem_wr) begin
                    state_next = S_IDLE;
                end
            end
`ifdef RAM_CLEAR_EN
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
                if (clr_addr == DEPTH_LOG2'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register, capture registers, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= RESET_STATE;
            wait_cnt    <= '0;
            cap_addr    <= '0;
            cap_data    <= '0;
            cap_wr      <= 1'b0;
            sw_meta     <= '0;
            sw_sync     <= '0;
            Data_to_CPU <= '0;
            mem_ready   <= 1'b0;
            hex_data    <= '0;
        end else begin
            state     <= state_next;
            sw_meta   <= SW;
            sw_sync   <= sw_meta;
            // Completion pulse is the registered image of the ACCESS cycle,
            // so it is high only in the first DONE cycle.
            mem_ready <= (state == S_ACCESS);

            if (capture) begin
                cap_addr <= ADDR;
                cap_data <= Data_from_CPU;
                cap_wr   <= mem_wr;
                wait_cnt <= CNT_W'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end

            if (state == S_ACCESS) begin
                if (cap_wr) begin
                    if (io_hit) begin
                        hex_data <= cap_data;
                    end
                end else begin
                    Data_to_CPU <= io_hit ? io_word
                                          : ram[cap_addr[DEPTH_LOG2-1:0]];
                end
            end
        end
    end

`ifdef RAM_CLEAR_EN
    // Reset restarts the fill from word 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clr_addr <= '0;
        end else if (state == S_CLEAR) begin
            clr_addr <= clr_addr + DEPTH_LOG2'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Word RAM: single write port, contents not reset
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_io_responder
//
// Directed bench for mem_io_responder. dut (WAIT_STATES=2) carries most of the
// sequence; dut_z (WAIT_STATES=0) covers zero-wait latency and the case where
// mem_rd and mem_wr are raised together. Expected read data is pushed into
// exp_q when a read is issued and popped when mem_ready is observed.
// -----------------------------------------------------------------------------
module tb_mem_io_responder;

    localparam int DW = 16;
    localparam int AW = 16;

    // ---------------- clock / reset ----------------
    logic Clk;
    logic Reset;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- dut (WAIT_STATES=2) ----------------
    logic          mem_rd, mem_wr;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] Data_from_CPU, Data_to_CPU, hex_data;
    logic          mem_ready, busy;
    logic [9:0]    SW;
    logic [2:0]    state_dbg;

    mem_io_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8),
                       .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU),
        .mem_ready(mem_ready), .busy(busy), .SW(SW), .hex_data(hex_data),
        .state_dbg(state_dbg)
    );

    // ---------------- dut_z (WAIT_STATES=0) ----------------
    logic          z_rd, z_wr;
    logic [AW-1:0] z_addr;
    logic [DW-1:0] z_wdata, z_dout, z_hex;
    logic          z_ready, z_busy;
    logic [2:0]    z_state;

    mem_io_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8),
                       .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut_z (
        .Clk(Clk), .Reset(Reset), .mem_rd(z_rd), .mem_wr(z_wr),
        .ADDR(z_addr), .Data_from_CPU(z_wdata), .Data_to_CPU(z_dout),
        .mem_ready(z_ready), .busy(z_busy), .SW(SW), .hex_data(z_hex),
        .state_dbg(z_state)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input bit sel);
        return sel ? z_ready : mem_ready;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? z_busy : busy;
    endfunction

    function automatic logic [DW-1:0] dout_of(input bit sel);
        return sel ? z_dout : Data_to_CPU;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit sel, input bit wr, input bit rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (sel) begin
            z_wr = wr; z_rd = rd; z_addr = a; z_wdata = d;
        end else begin
            mem_wr = wr; mem_rd = rd; ADDR = a; Data_from_CPU = d;
        end
    endtask

    // Called at a falling edge with the responder idle. Counts falling edges
    // from the sampling rising edge to the first one showing mem_ready.
    task automatic txn(input bit sel, input bit wr, input bit rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int hold, input bit drop_early);
        int lat;
        int pulses;
        logic [DW-1:0] exp_d;
        lat = 0;
        drive(sel, wr, rd, a, d);
        @(posedge Clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (drop_early && c == 1) drive(sel, 1'b0, 1'b0, a, d);
            if (rdy_of(sel) === 1'b1) begin
                lat = c;
                break;
            end
        end
        check(sel ? "latency_ws0" : "latency_ws2", 32'(lat), sel ? 32'd2 : 32'd4);
        if (rd && !wr) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_d = exp_q.pop_front();
                if (lat != 0) check("read_data", 32'(dout_of(sel)), 32'(exp_d));
            end
        end
        pulses = (lat != 0) ? 1 : 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            if (rdy_of(sel) === 1'b1) pulses++;
        end
        if (hold > 0) begin
            check("single_pulse", 32'(pulses), 32'd1);
            check("busy_while_held", 32'(busy_of(sel)), 32'd1);
        end
        drive(sel, 1'b0, 1'b0, a, d);
        @(negedge Clk);
        check("idle_busy", 32'(busy_of(sel)), 32'd0);
        check("idle_ready", 32'(rdy_of(sel)), 32'd0);
    endtask

    task automatic wr_txn(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn(sel, 1'b1, 1'b0, a, d, 0, 1'b0);
    endtask

    task automatic rd_txn(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
        exp_q.push_back(exp);
        txn(sel, 1'b0, 1'b1, a, '0, hold, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    logic [DW-1:0] rnd_d [4];
    logic [7:0]    rnd_hi[4];
    int            pulses;

    initial begin
        Reset = 1'b1;
        SW    = '0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge Clk);

        // Reset values
        check("rst_dout", 32'(Data_to_CPU), 32'h0);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hex", 32'(hex_data), 32'h0);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_rst_busy", 32'(busy), 32'h0);

        // Write then read back a RAM word; hex untouched
        wr_txn(1'b0, 16'h0005, 16'h1234);
        rd_txn(1'b0, 16'h0005, 16'h1234, 0);
        check("hex_after_ram", 32'(hex_data), 32'h0);

        // A write leaves Data_to_CPU alone
        wr_txn(1'b0, 16'h00FF, 16'h7777);
        check("dout_after_wr", 32'(Data_to_CPU), 32'h1234);

        // I/O write and switch read
        wr_txn(1'b0, 16'hFFFF, 16'hBEEF);
        check("hex_io_wr", 32'(hex_data), 32'hBEEF);
        SW = 10'b0000001011;
        repeat (3) @(negedge Clk);
        rd_txn(1'b0, 16'hFFFF, 16'h000B, 0);
        rd_txn(1'b0, 16'h00FF, 16'h7777, 0);
        check("hex_after_rd", 32'(hex_data), 32'hBEEF);

        // Upper address bits alias
        wr_txn(1'b0, 16'h0105, 16'hAAAA);
        rd_txn(1'b0, 16'h0005, 16'hAAAA, 0);

        // Request held 10 cycles past mem_ready
        rd_txn(1'b0, 16'h0005, 16'hAAAA, 10);

        // Random data across aliased addresses
        for (int i = 0; i < 4; i++) begin
            rnd_d[i]  = 16'($urandom_range(0, 16'hFFFF));
            rnd_hi[i] = 8'($urandom_range(0, 8'hFE));
            wr_txn(1'b0, {rnd_hi[i], 8'h20 + 8'(i)}, rnd_d[i]);
        end
        for (int i = 0; i < 4; i++) begin
            rd_txn(1'b0, {8'h00, 8'h20 + 8'(i)}, rnd_d[i], 0);
        end

        // Read dropped during WAIT still completes, DONE exits at once
        exp_q.push_back(16'hAAAA);
        txn(1'b0, 1'b0, 1'b1, 16'h0005, '0, 0, 1'b1);

        // Reset during WAIT of a write
        wr_txn(1'b0, 16'h0010, 16'h1111);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h5555);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ready", 32'(mem_ready), 32'h0);
        check("midrst_dout", 32'(Data_to_CPU), 32'h0);
        check("midrst_hex", 32'(hex_data), 32'h0);
        pulses = 0;
        repeat (2) begin
            @(negedge Clk);
            if (mem_ready === 1'b1) pulses++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        Reset = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (mem_ready === 1'b1) pulses++;
        end
        check("midrst_no_ready", 32'(pulses), 32'h0);
        check("midrst_idle", 32'(busy), 32'h0);
        rd_txn(1'b0, 16'h0010, 16'h1111, 0);

        // Zero wait states: rd and wr together performs the write
        txn(1'b1, 1'b1, 1'b1, 16'h0030, 16'hC3C3, 0, 1'b0);
        check("ws0_dout_kept", 32'(z_dout), 32'h0);
        check("ws0_hex", 32'(z_hex), 32'h0);
        rd_txn(1'b1, 16'h0030, 16'hC3C3, 0);
        wr_txn(1'b1, 16'hFFFF, 16'h0F0F);
        check("ws0_hex_wr", 32'(z_hex), 32'h0F0F);

        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
